sbox_subword_pipe: RTL

Parametrised, flow-controlled AES SubWord/InvSubWord engine. Applies the forward or inverse AES S-box, selectable per word, to each byte of an NUM_BYTES-wide word, using synchronous-read ROMs built from `generic_init_mem_2r` instances. It sits between the key-expansion or round datapath and its consumer. Valid/ready handshakes on both sides and an output FIFO absorb downstream stalls without losing in-flight ROM reads.

---
 rtl/sbox_subword_pipe.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sbox_subword_pipe.sv
// AES SubWord/InvSubWord engine: synchronous-read S-box ROMs feeding a credit-controlled output FIFO.
// Optional inverse bank enabled by defining SBOX_INV_EN.
`default_nettype none

module generic_init_mem_2r #(
   parameter string INIT_FILE = "sbox.init",
   parameter string INV_FILE  = "inv_sbox.init"
) (
   input  logic       clk,
   input  logic       en,
   input  logic [7:0] addr_a,
   input  logic [7:0] addr_b,
   output logic [7:0] rd_a,
   output logic [7:0] rd_b
);
   // The image named by INIT_FILE is generated from the AES field arithmetic;
   // an empty name yields a blank ROM.
   localparam bit IS_INV = (INIT_FILE == INV_FILE);
   localparam bit BLANK  = (INIT_FILE == "");

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse, and maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = x;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] rom_entry(input logic [7:0] a);
      logic [7:0] b;
      if (BLANK) begin
         b = 8'h00;
      end else if (IS_INV) begin
         b = gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
      end else begin
         b = gf_inv(a);
         b = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
      end
      return b;
   endfunction

   logic [7:0] rd_a_d, rd_a_q;
   logic [7:0] rd_b_d, rd_b_q;

   always_comb begin
      rd_a_d = rom_entry(addr_a);
      rd_b_d = rom_entry(addr_b);
   end

   always_ff @(posedge clk) begin
      if (en) begin
         rd_a_q <= rd_a_d;
         rd_b_q <= rd_b_d;
      end
   end

   assign rd_a = rd_a_q;
   assign rd_b = rd_b_q;
endmodule

module sbox_subword_pipe #(
   parameter int    NUM_BYTES = 4,
   parameter int    DEPTH     = 3,
   parameter string FWD_INIT  = "sbox.init",
   parameter string INV_INIT  = "inv_sbox.init",
   parameter int    CW        = $clog2(DEPTH + 1)
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   valid_in,
   output logic                   ready_out,
   input  logic                   inv_in,
   input  logic [8*NUM_BYTES-1:0] data_in,
   output logic                   valid_out,
   input  logic                   ready_in,
   output logic [8*NUM_BYTES-1:0] data_out,
   output logic [CW-1:0]          count_out
);
   localparam int W  = 8 * NUM_BYTES;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic          accept, push, pop;
   logic [CW-1:0] occupancy;
   logic [W-1:0]  fwd_word, rom_word;
   logic          v1_d, v1_q;
   logic [PW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
   logic [CW-1:0] fifo_count_d, fifo_count_q;
   logic [W-1:0]  fifo_mem_q [DEPTH];
`ifdef SBOX_INV_EN
   logic [W-1:0]  inv_word;
   logic          inv1_d, inv1_q;
`else
   logic          unused_inv;
   assign unused_inv = inv_in;
`endif

   // Two byte lanes per ROM instance, one per read port.
   for (genvar g = 0; g < NUM_BYTES / 2; g++) begin : g_lane_pair
      generic_init_mem_2r #(.INIT_FILE(FWD_INIT), .INV_FILE(INV_INIT)) u_fwd (
         .clk(clk_in), .en(accept),
         .addr_a(data_in[16*g +: 8]), .addr_b(data_in[16*g+8 +: 8]),
         .rd_a(fwd_word[16*g +: 8]),  .rd_b(fwd_word[16*g+8 +: 8])
      );
`ifdef SBOX_INV_EN
      generic_init_mem_2r #(.INIT_FILE(INV_INIT), .INV_FILE(INV_INIT)) u_inv (
         .clk(clk_in), .en(accept),
         .addr_a(data_in[16*g +: 8]), .addr_b(data_in[16*g+8 +: 8]),
         .rd_a(inv_word[16*g +: 8]),  .rd_b(inv_word[16*g+8 +: 8])
      );
`endif
   end

   always_comb begin
      // Credits count the word still in the ROM stage so a push never meets a full FIFO.
      occupancy = fifo_count_q + CW'(v1_q);
      ready_out = occupancy < CW'(DEPTH);
      count_out = occupancy;
      accept    = valid_in && ready_out;
      valid_out = (fifo_count_q != '0);
      pop       = valid_out && ready_in;
      push      = v1_q;
      data_out  = valid_out ? fifo_mem_q[rd_ptr_q] : '0;
      v1_d      = accept;
`ifdef SBOX_INV_EN
      inv1_d    = accept ? inv_in : inv1_q;
      rom_word  = inv1_q ? inv_word : fwd_word;
`else
      rom_word  = fwd_word;
`endif
      wr_ptr_d = wr_ptr_q;
      if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      rd_ptr_d = rd_ptr_q;
      if (pop) rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      fifo_count_d = fifo_count_q;
      if (push && !pop) fifo_count_d = fifo_count_q + 1'b1;
      else if (pop && !push) fifo_count_d = fifo_count_q - 1'b1;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         v1_q         <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_count_q <= '0;
`ifdef SBOX_INV_EN
         inv1_q       <= 1'b0;
`endif
      end else begin
         v1_q         <= v1_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fifo_count_q <= fifo_count_d;
`ifdef SBOX_INV_EN
         inv1_q       <= inv1_d;
`endif
      end
   end

   always_ff @(posedge clk_in) begin
      if (push) fifo_mem_q[wr_ptr_q] <= rom_word;
   end
endmodule

`default_nettype wire
